// File: rtl/riscv_pkg.sv
// Shared pipeline types: decoded control bundle, ALU operation codes and
// register-index width used by the ID/EX stage and its hazard logic.
package riscv_pkg;

    localparam int REG_IDX_W = 5;

    // ALU operation classes produced by the main decoder.
    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_RTYPE = 2'b10
    } alu_op_e;

    // Decoded control flags; the MSB-first order matches the id_ctrl bus.
    typedef struct packed {
        logic alu_src;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic branch;
    } ctrl_t;

    // A bubble carries no side effects at all.
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX bundle: the decoded instruction from ID plus the pipeline-control
// inputs, and the registered EX view with stall and bubble statistics.
interface id_ex_stage_if
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);

    // Decode side
    logic                 id_valid;
    logic [1:0]           id_alu_op;
    logic [3:0]           id_funct73;
    logic [XLEN-1:0]      id_rs1_data;
    logic [XLEN-1:0]      id_rs2_data;
    logic [XLEN-1:0]      id_imm;
    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic [REG_IDX_W-1:0] id_rd;
    ctrl_t                id_ctrl;
    logic                 id_uses_rs2;
    logic                 flush;
    logic                 hold;

    // Execute side
    logic                 ex_valid;
    logic [1:0]           ex_alu_op;
    logic [3:0]           ex_funct73;
    logic [XLEN-1:0]      ex_rs1_data;
    logic [XLEN-1:0]      ex_rs2_data;
    logic [XLEN-1:0]      ex_imm;
    logic [REG_IDX_W-1:0] ex_rs1;
    logic [REG_IDX_W-1:0] ex_rs2;
    logic [REG_IDX_W-1:0] ex_rd;
    ctrl_t                ex_ctrl;
    logic                 stall_if_id;
    logic [CNT_W-1:0]     bubble_cnt;

    // Decode stage (or bench) drives the instruction and sees the EX view.
    modport master (
        output id_valid, id_alu_op, id_funct73, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_ctrl, id_uses_rs2, flush, hold,
        input  ex_valid, ex_alu_op, ex_funct73, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl, stall_if_id, bubble_cnt
    );

    // The pipeline register consumes the instruction and produces the EX view.
    modport slave (
        input  id_valid, id_alu_op, id_funct73, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_ctrl, id_uses_rs2, flush, hold,
        output ex_valid, ex_alu_op, ex_funct73, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl, stall_if_id, bubble_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detection: the instruction in ID reads a register that the
// load currently in EX has not yet fetched from memory.
module hazard_detect
    import riscv_pkg::*;
(
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs2,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 load_use
);

    // x0 is never a real producer, so a load targeting it cannot cause a stall.
    assign load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                      ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register. Flush and load-use insert bubbles,
// hold freezes the stage, and load-use bubbles are counted (saturating).
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
)(
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic load_use;

    hazard_detect u_hazard (
        .id_valid    (bus.id_valid),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_uses_rs2 (bus.id_uses_rs2),
        .ex_valid    (bus.ex_valid),
        .ex_mem_read (bus.ex_ctrl.mem_read),
        .ex_rd       (bus.ex_rd),
        .load_use    (load_use)
    );

    // A redirect discards the ID instruction, so no stall is needed then.
    assign bus.stall_if_id = (load_use | bus.hold) & ~bus.flush;

    // Stage register and bubble counter: flush > hold > load-use > advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every stage register is reset (not just ex_valid) so a
            // cleared pipeline shows all-zero data to EX and to observers.
            bus.ex_valid    <= 1'b0;
            bus.ex_alu_op   <= ALU_OP_ADD;
            bus.ex_funct73  <= '0;
            bus.ex_rs1_data <= '0;
            bus.ex_rs2_data <= '0;
            bus.ex_imm      <= '0;
            bus.ex_rs1      <= '0;
            bus.ex_rs2      <= '0;
            bus.ex_rd       <= '0;
            bus.ex_ctrl     <= CTRL_NOP;
            bus.bubble_cnt  <= '0;
        end else if (bus.flush || (!bus.hold && load_use)) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, including ex_rd/ex_ctrl feeding load_use.
            bus.ex_valid    <= 1'b0;
            bus.ex_alu_op   <= ALU_OP_ADD;
            bus.ex_funct73  <= '0;
            bus.ex_rs1_data <= {XLEN{1'b0}};
            bus.ex_rs2_data <= {XLEN{1'b0}};
            bus.ex_imm      <= {XLEN{1'b0}};
            bus.ex_rs1      <= '0;
            bus.ex_rs2      <= '0;
            bus.ex_rd       <= '0;
            bus.ex_ctrl     <= CTRL_NOP;
            // Only hazard bubbles are counted; redirects are not stalls.
            if (!bus.flush && bus.bubble_cnt != CNT_MAX) begin
                bus.bubble_cnt <= bus.bubble_cnt + 1'b1;
            end
        end else if (!bus.hold) begin
            bus.ex_valid    <= bus.id_valid;
            bus.ex_alu_op   <= bus.id_alu_op;
            bus.ex_funct73  <= bus.id_funct73;
            bus.ex_rs1_data <= bus.id_rs1_data;
            bus.ex_rs2_data <= bus.id_rs2_data;
            bus.ex_imm      <= bus.id_imm;
            bus.ex_rs1      <= bus.id_rs1;
            bus.ex_rs2      <= bus.id_rs2;
            bus.ex_rd       <= bus.id_rd;
            // An empty ID slot must not leak stale control into EX.
            bus.ex_ctrl     <= bus.id_valid ? bus.id_ctrl : CTRL_NOP;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush/hold/reset scenarios followed by
// random traffic, checked against a slot-level reference model via a queue.
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int XLEN  = 32;
    // Narrow counter so saturation is reachable in a short run.
    localparam int CNT_W = 8;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    // Decoded instruction as presented by ID.
    typedef struct packed {
        logic        valid;
        logic [1:0]  alu_op;
        logic [3:0]  funct73;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        ctrl_t       ctrl;
        logic        uses_rs2;
    } instr_t;

    // Everything EX observes, plus the bubble counter.
    typedef struct packed {
        logic             valid;
        logic [1:0]       alu_op;
        logic [3:0]       funct73;
        logic [31:0]      rs1_data;
        logic [31:0]      rs2_data;
        logic [31:0]      imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        ctrl_t            ctrl;
        logic [CNT_W-1:0] cnt;
    } slot_t;

    localparam ctrl_t C_LW  = 6'b110110; // alu_src, mem_read, reg_write, mem_to_reg
    localparam ctrl_t C_ADD = 6'b000100; // reg_write
    localparam ctrl_t C_SW  = 6'b101000; // alu_src, mem_write

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    slot_t mdl;              // what EX should hold right now
    int    mdl_bubbles = 0;  // unbounded count of hazard bubbles
    slot_t exp_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic slot_t sample_dut();
        slot_t s;
        s.valid    = bus.ex_valid;
        s.alu_op   = bus.ex_alu_op;
        s.funct73  = bus.ex_funct73;
        s.rs1_data = bus.ex_rs1_data;
        s.rs2_data = bus.ex_rs2_data;
        s.imm      = bus.ex_imm;
        s.rs1      = bus.ex_rs1;
        s.rs2      = bus.ex_rs2;
        s.rd       = bus.ex_rd;
        s.ctrl     = bus.ex_ctrl;
        s.cnt      = bus.bubble_cnt;
        return s;
    endfunction

    // ID must wait when it reads the destination of the load sitting in EX.
    function automatic bit needs_load_data(slot_t ex, instr_t id);
        bit reads_rd;
        reads_rd = (ex.rd == id.rs1) || (id.uses_rs2 && ex.rd == id.rs2);
        return id.valid && ex.valid && ex.ctrl.mem_read && ex.rd != 5'd0 && reads_rd;
    endfunction

    function automatic logic [CNT_W-1:0] sat_count(int n);
        return (n >= CNT_SAT) ? CNT_SAT[CNT_W-1:0] : n[CNT_W-1:0];
    endfunction

    function automatic instr_t mk(bit v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                  ctrl_t c, bit u2);
        instr_t i;
        i.valid    = v;
        i.alu_op   = 2'($urandom_range(0, 2));
        i.funct73  = 4'($urandom);
        i.rs1_data = $urandom;
        i.rs2_data = $urandom;
        i.imm      = $urandom;
        i.rs1      = rs1;
        i.rs2      = rs2;
        i.rd       = rd;
        i.ctrl     = c;
        i.uses_rs2 = u2;
        return i;
    endfunction

    task automatic drive(input instr_t i, input bit fl, input bit ho);
        bus.id_valid    = i.valid;
        bus.id_alu_op   = i.alu_op;
        bus.id_funct73  = i.funct73;
        bus.id_rs1_data = i.rs1_data;
        bus.id_rs2_data = i.rs2_data;
        bus.id_imm      = i.imm;
        bus.id_rs1      = i.rs1;
        bus.id_rs2      = i.rs2;
        bus.id_rd       = i.rd;
        bus.id_ctrl     = i.ctrl;
        bus.id_uses_rs2 = i.uses_rs2;
        bus.flush       = fl;
        bus.hold        = ho;
    endtask

    // One clock of traffic: present ID, check the combinational stall and that
    // EX has not moved yet, then queue what EX must hold after the edge.
    task automatic cycle(input instr_t i, input bit fl, input bit ho);
        bit hz;
        slot_t nxt;
        @(negedge clk);
        drive(i, fl, ho);
        #1;
        hz = needs_load_data(mdl, i);
        check("stall_if_id", 256'(bus.stall_if_id), 256'(!fl && (hz || ho)));
        check("ex_before_edge", 256'(sample_dut()), 256'(mdl));
        nxt = mdl;
        if (fl) begin
            nxt = '0;
        end else if (ho) begin
            nxt = mdl;
        end else if (hz) begin
            nxt = '0;
            mdl_bubbles++;
        end else begin
            nxt = '0;
            nxt.valid    = i.valid;
            nxt.alu_op   = i.alu_op;
            nxt.funct73  = i.funct73;
            nxt.rs1_data = i.rs1_data;
            nxt.rs2_data = i.rs2_data;
            nxt.imm      = i.imm;
            nxt.rs1      = i.rs1;
            nxt.rs2      = i.rs2;
            nxt.rd       = i.rd;
            nxt.ctrl     = i.valid ? i.ctrl : CTRL_NOP;
        end
        nxt.cnt = sat_count(mdl_bubbles);
        mdl = nxt;
        exp_q.push_back(nxt);
    endtask

    // Monitor: after each edge, compare EX against the oldest expectation.
    initial begin
        slot_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = sample_dut();
                check("ex_after_edge", 256'(a), 256'(e));
                if (a.valid == 1'b0) begin
                    check("bubble_side_effects",
                          256'({a.ctrl.reg_write, a.ctrl.mem_write, a.ctrl.mem_read, a.ctrl.branch}),
                          256'(0));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    instr_t idle;
    instr_t t;

    initial begin
        idle = '0;
        mdl  = '0;
        rst_n = 1'b0;
        drive(idle, 1'b0, 1'b0);
        #12;
        check("reset_state", 256'(sample_dut()), 256'(0));
        check("reset_stall", 256'(bus.stall_if_id), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Pass-through of an R-type instruction.
        t = mk(1'b1, 5'd1, 5'd2, 5'd7, C_ADD, 1'b1);
        t.alu_op = 2'b10; t.funct73 = 4'b1000; t.rs1_data = 32'd5; t.rs2_data = 32'd3;
        cycle(t, 1'b0, 1'b0);
        cycle(idle, 1'b0, 1'b0);

        // Load-use on rs1: one bubble, then the add enters EX.
        cycle(mk(1'b1, 5'd1, 5'd0, 5'd5, C_LW, 1'b0), 1'b0, 1'b0);
        t = mk(1'b1, 5'd5, 5'd2, 5'd6, C_ADD, 1'b1);
        cycle(t, 1'b0, 1'b0);
        cycle(t, 1'b0, 1'b0);
        check("bubble_cnt_first", 256'(mdl.cnt), 256'(1));

        // Load to x0 never stalls.
        cycle(mk(1'b1, 5'd1, 5'd0, 5'd0, C_LW, 1'b0), 1'b0, 1'b0);
        cycle(mk(1'b1, 5'd0, 5'd0, 5'd6, C_ADD, 1'b1), 1'b0, 1'b0);

        // rs2 match only matters when the instruction reads rs2.
        cycle(mk(1'b1, 5'd1, 5'd0, 5'd4, C_LW, 1'b0), 1'b0, 1'b0);
        cycle(mk(1'b1, 5'd1, 5'd4, 5'd0, C_SW, 1'b0), 1'b0, 1'b0);
        cycle(mk(1'b1, 5'd1, 5'd0, 5'd4, C_LW, 1'b0), 1'b0, 1'b0);
        cycle(mk(1'b1, 5'd1, 5'd4, 5'd0, C_SW, 1'b1), 1'b0, 1'b0);
        cycle(idle, 1'b0, 1'b0);

        // Flush beats hold and load-use.
        cycle(mk(1'b1, 5'd1, 5'd0, 5'd5, C_LW, 1'b0), 1'b0, 1'b0);
        cycle(mk(1'b1, 5'd5, 5'd0, 5'd6, C_ADD, 1'b0), 1'b1, 1'b1);

        // Hold beats load-use; the hazard is taken once hold drops.
        cycle(mk(1'b1, 5'd1, 5'd0, 5'd5, C_LW, 1'b0), 1'b0, 1'b0);
        t = mk(1'b1, 5'd5, 5'd0, 5'd6, C_ADD, 1'b0);
        cycle(t, 1'b0, 1'b1);
        cycle(t, 1'b0, 1'b1);
        cycle(t, 1'b0, 1'b0);
        cycle(t, 1'b0, 1'b0);

        // Reset mid-stream while a load sits in EX and ID depends on it.
        cycle(mk(1'b1, 5'd1, 5'd0, 5'd9, C_LW, 1'b0), 1'b0, 1'b0);
        @(negedge clk);
        drive(mk(1'b1, 5'd9, 5'd0, 5'd3, C_ADD, 1'b0), 1'b0, 1'b0);
        #1;
        check("pre_reset_stall", 256'(bus.stall_if_id), 256'(1));
        rst_n = 1'b0;
        #1;
        check("mid_reset_state", 256'(sample_dut()), 256'(0));
        check("mid_reset_stall", 256'(bus.stall_if_id), 256'(0));
        mdl = '0;
        mdl_bubbles = 0;
        @(negedge clk);
        drive(idle, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Random traffic with small register indices to provoke hazards.
        for (int n = 0; n < 2000; n++) begin
            t = mk($urandom_range(0, 9) < 8,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   ctrl_t'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) t.ctrl.mem_read = 1'b1;
            cycle(t, $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
        end

        // Saturation: more load-use bubbles than the counter can represent.
        for (int n = 0; n < (1 << CNT_W) + 3; n++) begin
            cycle(mk(1'b1, 5'd1, 5'd0, 5'd5, C_LW, 1'b0), 1'b0, 1'b0);
            cycle(mk(1'b1, 5'd5, 5'd0, 5'd6, C_ADD, 1'b0), 1'b0, 1'b0);
        end
        cycle(idle, 1'b0, 1'b0);

        for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clk);
        check("queue_drained", 256'(exp_q.size()), 256'(0));
        check("bubble_cnt_saturated", 256'(bus.bubble_cnt), 256'(CNT_SAT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
